// File: rtl/mode_arbiter_pkg.sv
// Shared types for mode_arbiter: stopwatch FSM encoding and function indices.
// Pure definitions; no latency or backpressure.
package mode_arbiter_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2
  } sw_state_t;

  localparam logic [1:0] FN_CLOCK = 2'd0;
  localparam logic [1:0] FN_SW    = 2'd1;
  localparam logic [1:0] FN_TIMER = 2'd2;
  localparam logic [1:0] FN_ALARM = 2'd3;

  function automatic logic [3:0] fn_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mode_arbiter_btn_debounce.sv
// Push-button synchronizer + ms-tick debouncer; pulse is combinational, one cycle
// on the accepted 0->1 change. No backpressure: the pulse is fire-and-forget.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic ms_tick,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS + 1) : 1;

  logic [1:0]    sync_ff;
  logic          sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic          accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff <= 2'b00;
    end else begin
      sync_ff <= {sync_ff[0], raw};
    end
  end

  assign sync   = sync_ff[1];
  assign accept = ms_tick && (sync != level) && (cnt == CW'(DEBOUNCE_MS - 1));
  assign pulse  = accept && sync;

  // Any cycle where the input agrees with the accepted level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync == level) begin
      cnt <= '0;
    end else if (ms_tick) begin
      if (accept) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mode_arbiter.sv
// Routes debounced start/modify pulses to the function picked by the mode switches and
// runs the stopwatch FSM; pulses/owner registered (1 cycle), no backpressure. Option: LAP_EN.
module mode_arbiter
  import mode_arbiter_pkg::*;
#(
  parameter int CLK_PER_MS  = 100000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       modify,
  input  logic [3:0] mode,
  output logic [1:0] owner,
  output logic [3:0] ld_mode,
  output logic [3:0] start_p,
  output logic [3:0] modify_p,
  output logic       sw_run,
  output logic       sw_clr,
  output logic       lap_hold
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  logic [PW-1:0] pre_cnt;
  logic          ms_tick;
  logic [3:0]    mode_s1, mode_s2;
  logic          start_pulse, modify_pulse;
  logic [1:0]    owner_nxt;
  sw_state_t     state, state_nxt;
  logic          clr_nxt;
  logic          sw_start, sw_mod;

  assign ms_tick = (pre_cnt == PW'(CLK_PER_MS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (ms_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_s1 <= 4'b0000;
      mode_s2 <= 4'b0000;
    end else begin
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
    end
  end

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start_db (
    .clk     (clk),
    .reset   (reset),
    .raw     (start),
    .ms_tick (ms_tick),
    .pulse   (start_pulse)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_modify_db (
    .clk     (clk),
    .reset   (reset),
    .raw     (modify),
    .ms_tick (ms_tick),
    .pulse   (modify_pulse)
  );

  always_comb begin
    owner_nxt = owner;
    case (mode_s2)
      4'b0001: owner_nxt = FN_CLOCK;
      4'b0010: owner_nxt = FN_SW;
      4'b0100: owner_nxt = FN_TIMER;
      4'b1000: owner_nxt = FN_ALARM;
      default: owner_nxt = owner;
    endcase
  end

  // Routing by owner_nxt lets a pulse that coincides with a switch change follow the new owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= FN_CLOCK;
      start_p  <= 4'b0000;
      modify_p <= 4'b0000;
    end else begin
      owner    <= owner_nxt;
      start_p  <= start_pulse  ? fn_onehot(owner_nxt) : 4'b0000;
      modify_p <= modify_pulse ? fn_onehot(owner_nxt) : 4'b0000;
    end
  end

  assign ld_mode  = fn_onehot(owner);
  assign sw_start = start_p[FN_SW];
  assign sw_mod   = modify_p[FN_SW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= SW_IDLE;
      sw_clr <= 1'b0;
    end else begin
      state  <= state_nxt;
      sw_clr <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    case (state)
      SW_IDLE: begin
        if (sw_start) state_nxt = SW_RUN;
      end
      SW_RUN: begin
        if (sw_start) state_nxt = SW_PAUSE;
      end
      SW_PAUSE: begin
        if (sw_start) begin
          state_nxt = SW_RUN;
        end else if (sw_mod) begin
          state_nxt = SW_IDLE;
          clr_nxt   = 1'b1;
        end
      end
      default: state_nxt = SW_IDLE;
    endcase
  end

  assign sw_run = (state == SW_RUN);

`ifdef LAP_EN
  logic lap_nxt;

  always_comb begin
    lap_nxt = lap_hold;
    if (state == SW_RUN && !sw_start && sw_mod) begin
      lap_nxt = ~lap_hold;
    end else if (state != SW_IDLE && state_nxt == SW_IDLE) begin
      lap_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_hold <= 1'b0;
    end else begin
      lap_hold <= lap_nxt;
    end
  end
`else
  assign lap_hold = 1'b0;
`endif

endmodule

// File: tb/tb_mode_arbiter.sv
// Randomized and directed bench for mode_arbiter against a cycle-stepped behavioural model.
// Build with or without LAP_EN; expectations follow the same macro.
module tb_mode_arbiter;

  localparam int CPM = 10;
  localparam int DB  = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
`ifdef LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       modify = 1'b0;
  logic [3:0] mode = 4'b0000;
  logic [1:0] owner;
  logic [3:0] ld_mode, start_p, modify_p;
  logic       sw_run, sw_clr, lap_hold;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mode_arbiter #(.CLK_PER_MS(CPM), .DEBOUNCE_MS(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .modify   (modify),
    .mode     (mode),
    .owner    (owner),
    .ld_mode  (ld_mode),
    .start_p  (start_p),
    .modify_p (modify_p),
    .sw_run   (sw_run),
    .sw_clr   (sw_clr),
    .lap_hold (lap_hold)
  );

  // Reference model: ms ticks from elapsed cycles, syncs as 2-deep delay lines,
  // debounce as a count of consecutive disagreeing ticks, stopwatch as a plain state table.
  int         m_edges, m_st;
  int         m_run [2];
  bit         m_lvl [2];
  bit         m_d1 [2];
  bit         m_d2 [2];
  logic [3:0] m_md1, m_md2, m_sp, m_mp;
  logic [1:0] m_owner;
  bit         m_clr, m_lap;

  always @(posedge clk or posedge reset) begin : model
    bit tick;
    bit ev [2];
    bit raw [2];
    if (reset) begin
      m_edges = 0; m_st = M_IDLE; m_md1 = 4'b0; m_md2 = 4'b0;
      m_sp = 4'b0; m_mp = 4'b0; m_owner = 2'd0; m_clr = 1'b0; m_lap = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_run[b] = 0; m_lvl[b] = 1'b0; m_d1[b] = 1'b0; m_d2[b] = 1'b0;
      end
    end else begin
      tick = (m_edges % CPM) == CPM - 1;
      m_edges++;
      m_clr = 1'b0;
      if (m_sp[1]) begin
        m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
      end else if (m_mp[1]) begin
        if (m_st == M_PAUSE) begin
          m_st = M_IDLE; m_clr = 1'b1; m_lap = 1'b0;
        end else if (m_st == M_RUN && LAP) begin
          m_lap = !m_lap;
        end
      end
      if ($countones(m_md2) == 1) begin
        for (int i = 0; i < 4; i++) if (m_md2[i]) m_owner = 2'(i);
      end
      raw[0] = start;
      raw[1] = modify;
      for (int b = 0; b < 2; b++) begin
        ev[b] = 1'b0;
        if (m_d2[b] == m_lvl[b]) begin
          m_run[b] = 0;
        end else if (tick) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_lvl[b] = m_d2[b]; m_run[b] = 0; ev[b] = m_lvl[b];
          end
        end
        m_d2[b] = m_d1[b];
        m_d1[b] = raw[b];
      end
      m_sp  = ev[0] ? (4'b0001 << m_owner) : 4'b0000;
      m_mp  = ev[1] ? (4'b0001 << m_owner) : 4'b0000;
      m_md2 = m_md1;
      m_md1 = mode;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // Holds one button for `hold` cycles, releases for `hold`, and tallies what came out.
  task automatic press(input bit is_mod, input int hold, output int n_sp1, output int n_mp1,
                       output int n_clr, output logic [3:0] last_sp);
    n_sp1 = 0; n_mp1 = 0; n_clr = 0; last_sp = 4'b0;
    if (is_mod) modify = 1'b1; else start = 1'b1;
    for (int i = 0; i < 2 * hold; i++) begin
      @(negedge clk);
      if (start_p[1]) n_sp1++;
      if (modify_p[1]) n_mp1++;
      if (sw_clr) n_clr++;
      if (start_p != 4'b0) last_sp = start_p;
      if (i == hold - 1) begin start = 1'b0; modify = 1'b0; end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_tests++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    n_tests++; if (ld_mode !== 4'b0001) begin n_fail++; $display("FAIL reset_ld_mode: got %b expected 0001", ld_mode); end
    n_tests++; if ({start_p, modify_p} !== 8'h00) begin n_fail++; $display("FAIL reset_pulses: got %h expected 00", {start_p, modify_p}); end
    n_tests++; if ({sw_run, sw_clr, lap_hold} !== 3'b000) begin n_fail++; $display("FAIL reset_sw: got %b expected 000", {sw_run, sw_clr, lap_hold}); end
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_owner();
    mode = 4'b0010; step(5);
    n_tests++; if (owner !== 2'd1) begin n_fail++; $display("FAIL owner_sw: got %0d expected 1", owner); end
    n_tests++; if (ld_mode !== 4'b0010) begin n_fail++; $display("FAIL ld_mode_sw: got %b expected 0010", ld_mode); end
    mode = 4'b0110; step(5);
    n_tests++; if (owner !== 2'd1) begin n_fail++; $display("FAIL owner_multi: got %0d expected 1", owner); end
    mode = 4'b0000; step(5);
    n_tests++; if (owner !== 2'd1) begin n_fail++; $display("FAIL owner_none: got %0d expected 1", owner); end
    mode = 4'b1000; step(5);
    n_tests++; if ({owner, ld_mode} !== {2'd3, 4'b1000}) begin n_fail++; $display("FAIL owner_alarm: got %0d/%b expected 3/1000", owner, ld_mode); end
    mode = 4'b0010; step(5);
    n_tests++; if (owner !== m_owner) begin n_fail++; $display("FAIL owner_model: got %0d expected %0d", owner, m_owner); end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int pattern [3] = '{3, 4, 48};
    for (int seg = 0; seg < 3; seg++) begin
      start = (seg != 1);
      for (int i = 0; i < pattern[seg]; i++) begin
        @(negedge clk);
        if (start_p[1]) pulses++;
        n_tests++;
        if (start_p !== m_sp) begin n_fail++; $display("FAIL bounce_trace: got %b expected %b", start_p, m_sp); end
      end
    end
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
    n_tests++; if (sw_run !== 1'b1) begin n_fail++; $display("FAIL bounce_run: got %b expected 1", sw_run); end
    start = 1'b0;
    step(40);
  endtask

  task automatic test_sequence();
    int sp, mp, clr;
    logic [3:0] lsp;
    pulse_reset();
    mode = 4'b0010; step(5);
    press(1'b0, 30, sp, mp, clr, lsp);
    n_tests++; if ({sp, 31'(sw_run)} !== {32'd1, 31'd1}) begin n_fail++; $display("FAIL seq_start1: got pulses %0d run %b expected 1/1", sp, sw_run); end
    press(1'b0, 30, sp, mp, clr, lsp);
    n_tests++; if (sw_run !== 1'b0) begin n_fail++; $display("FAIL seq_pause: got run %b expected 0", sw_run); end
    press(1'b1, 30, sp, mp, clr, lsp);
    n_tests++; if (clr != 1) begin n_fail++; $display("FAIL seq_clr_width: got %0d cycles expected 1", clr); end
    n_tests++; if ({sw_run, lap_hold} !== 2'b00 || m_st != M_IDLE) begin n_fail++; $display("FAIL seq_idle: got run/lap %b%b expected 00", sw_run, lap_hold); end
    press(1'b1, 30, sp, mp, clr, lsp);
    n_tests++; if (clr != 0 || sw_run !== 1'b0) begin n_fail++; $display("FAIL seq_idle_modify: got clr %0d run %b expected 0/0", clr, sw_run); end
    press(1'b0, 30, sp, mp, clr, lsp);
    n_tests++; if (sw_run !== 1'b1) begin n_fail++; $display("FAIL seq_restart: got run %b expected 1", sw_run); end
  endtask

  task automatic test_background();
    int sp, mp, clr;
    logic [3:0] lsp;
    mode = 4'b0001; step(5);
    n_tests++; if (owner !== 2'd0) begin n_fail++; $display("FAIL bg_owner: got %0d expected 0", owner); end
    press(1'b0, 30, sp, mp, clr, lsp);
    n_tests++; if (lsp !== 4'b0001 || sp != 0) begin n_fail++; $display("FAIL bg_route: got %b (sw pulses %0d) expected 0001/0", lsp, sp); end
    n_tests++; if (sw_run !== 1'b1) begin n_fail++; $display("FAIL bg_run: got %b expected 1", sw_run); end
  endtask

  task automatic test_lap();
    int sp, mp, clr;
    logic [3:0] lsp;
    mode = 4'b0010; step(5);
    press(1'b1, 30, sp, mp, clr, lsp);
    n_tests++; if (lap_hold !== LAP) begin n_fail++; $display("FAIL lap_first: got %b expected %b", lap_hold, LAP); end
    n_tests++; if (sw_run !== 1'b1) begin n_fail++; $display("FAIL lap_run: got %b expected 1", sw_run); end
    press(1'b1, 30, sp, mp, clr, lsp);
    n_tests++; if ({lap_hold, sw_run} !== 2'b01) begin n_fail++; $display("FAIL lap_second: got lap/run %b%b expected 01", lap_hold, sw_run); end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    int clr_seen = 0;
    start = 1'b1;
    step(8);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({owner, ld_mode, start_p, modify_p, sw_run, sw_clr, lap_hold} !== {2'd0, 4'b0001, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b expected %b", {owner, ld_mode, start_p, modify_p, sw_run, sw_clr, lap_hold}, {2'd0, 4'b0001, 8'h00, 3'b000});
    end
    step(3);
    reset = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (start_p != 4'b0 && first < 0) first = i;
      if (sw_clr) clr_seen++;
    end
    n_tests++; if (first < 20 || first > 22) begin n_fail++; $display("FAIL midreset_first_pulse: got cycle %0d expected 20..22", first); end
    n_tests++; if (clr_seen != 0) begin n_fail++; $display("FAIL midreset_clr: got %0d expected 0", clr_seen); end
    n_tests++; if (sw_run !== 1'b1) begin n_fail++; $display("FAIL midreset_run: got %b expected 1", sw_run); end
    start = 1'b0;
    step(40);
  endtask

  task automatic test_random();
    int hold_s = 0, hold_m = 0, hold_md = 0;
    logic [12:0] got, exp;
    pulse_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      got = {owner, start_p, modify_p, sw_run, sw_clr, lap_hold};
      exp = {m_owner, m_sp, m_mp, m_st == M_RUN, m_clr, m_lap};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL random_c%0d: got %b expected %b", cyc, got, exp); end
      if (hold_s == 0) begin start = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 40); end else hold_s--;
      if (hold_m == 0) begin modify = 1'($urandom_range(0, 1)); hold_m = $urandom_range(1, 40); end else hold_m--;
      if (hold_md == 0) begin
        mode = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0010;
        hold_md = $urandom_range(20, 200);
      end else hold_md--;
    end
    start = 1'b0; modify = 1'b0;
  endtask

  initial begin
    test_reset();
    test_owner();
    test_bounce();
    test_sequence();
    test_background();
    test_lap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mode_arbiter.md
MODE_ARBITER -- requirements
Module: mode_arbiter

Interface
REQ-001 Parameter CLK_PER_MS, default 100000, meaning clk cycles per 1 ms tick.
REQ-002 Parameter DEBOUNCE_MS, default 20, meaning ms a button level must hold stable to be accepted.
REQ-003 Port clk  in  1  system clock, all logic on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port start  in  1  raw start push-button, asynchronous to clk.
REQ-006 Port modify  in  1  raw modify push-button, asynchronous to clk.
REQ-007 Port mode  in  4  raw slide switches; bit i requests function i (0 clock, 1 stopwatch, 2 timer, 3 alarm).
REQ-008 Port owner  out  2  index of the function currently owning buttons and display.
REQ-009 Port ld_mode  out  4  one-hot of owner, for the mode LEDs.
REQ-010 Port start_p  out  4  one-cycle start pulse routed to owner bit only.
REQ-011 Port modify_p  out  4  one-cycle modify pulse routed to owner bit only.
REQ-012 Port sw_run  out  1  stopwatch count enable.
REQ-013 Port sw_clr  out  1  one-cycle stopwatch clear.
REQ-014 Port lap_hold  out  1  freeze the stopwatch display value.

Function
REQ-015 Prescaler SHALL emit an internal ms_tick for one cycle every CLK_PER_MS cycles, free-running, wrapping at CLK_PER_MS-1.
REQ-016 start, modify and mode SHALL each pass through a 2-flop synchronizer before any use.
REQ-017 Debounced button level SHALL change only after the synchronized level differs from it on DEBOUNCE_MS consecutive ms_ticks; any bounce restarts the count.
REQ-018 A 0->1 debounced transition SHALL produce exactly one single-cycle internal pulse; held buttons produce no repeat.
REQ-019 owner SHALL update to index i when the synchronized mode has exactly bit i set; zero or multiple bits set hold owner unchanged.
REQ-020 start_p[owner] and modify_p[owner] SHALL equal the internal pulses in the same cycle; all other bits 0.
REQ-021 Pulse coincident with an owner change SHALL go to the new owner.
REQ-022 Stopwatch FSM states SW_IDLE, SW_RUN, SW_PAUSE, driven only by start_p[1] and modify_p[1].
REQ-023 SW_IDLE: start -> SW_RUN; modify ignored.
REQ-024 SW_RUN: start -> SW_PAUSE; modify handled per REQ-033/034.
REQ-025 SW_PAUSE: start -> SW_RUN; modify -> SW_IDLE with sw_clr high for exactly the transition cycle.
REQ-026 sw_run SHALL be 1 iff state is SW_RUN (registered, no combinational path from buttons).
REQ-027 Start and modify pulses in the same cycle: start acts, modify dropped.
REQ-028 Owner changing away from 1 SHALL leave FSM state, sw_run and lap_hold unchanged (stopwatch runs in background).
REQ-029 lap_hold SHALL clear on entry to SW_IDLE and persist through SW_PAUSE.

Reset
REQ-030 reset assertion SHALL immediately force: owner=0, ld_mode=4'b0001, start_p=0, modify_p=0, sw_run=0, sw_clr=0, lap_hold=0, FSM=SW_IDLE, prescaler and debounce counters 0, debounced levels 0.
REQ-031 Buttons held across reset deassertion SHALL produce a pulse only after a full debounce interval.
REQ-032 Reset mid-debounce or mid-run SHALL discard the pending event; no sw_clr pulse is generated by reset.

Configuration
REQ-033 With LAP_EN defined, modify_p[1] in SW_RUN SHALL toggle lap_hold, state unchanged.
REQ-034 Without LAP_EN, lap_hold SHALL be constant 0 and modify in SW_RUN ignored.

Structure
REQ-035 Shared package holds FSM state encodings, function index constants (FN_CLOCK=0, FN_SW=1, FN_TIMER=2, FN_ALARM=3).
REQ-036 One sub-module btn_debounce (sync, counter, edge pulse), instantiated twice.

Verification
Use CLK_PER_MS=10, DEBOUNCE_MS=2 in all scenarios.
REQ-037 Reset, mode=4'b0010 held 5 cycles -> owner=1, ld_mode=4'b0010; mode=4'b0110 -> owner stays 1.
REQ-038 start bouncing 1-0-1 within 15 cycles then held 40 cycles -> exactly one start_p[1] pulse, sw_run=1.
REQ-039 owner=1, start, start, modify -> sw_run 1 then 0, sw_clr one cycle, FSM SW_IDLE.
REQ-040 In SW_RUN switch mode to 4'b0001, press start -> start_p=4'b0001, sw_run stays 1.
REQ-041 LAP_EN build, SW_RUN, modify twice -> lap_hold 1 then 0; non-LAP_EN build -> lap_hold always 0.
REQ-042 Assert reset in SW_RUN with start held -> all outputs reset values same cycle; no pulse until 20 cycles after release.
